// File: rtl/uart_rgb_ctrl_pkg.sv
// Shared definitions for the UART RGB duty controller: default frame header,
// FSM state encodings and the bit-period helper.
package uart_rgb_ctrl_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    P_WAIT_SYNC = 2'd0,
    P_GET_R     = 2'd1,
    P_GET_G     = 2'd2,
    P_GET_B     = 2'd3
  } parse_state_t;

  // Clocks spent on one serial bit (integer division, rounds down).
  function automatic int calc_clocks_per_bit(input int clock_freq, input int baud);
    return clock_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rgb_ctrl_uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, start-bit glitch rejection,
// LSB-first data capture and stop-bit check. Pulses are one clock wide.
module uart_rx
  import uart_rgb_ctrl_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 86
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rxd,
  output logic [7:0] o_rx_byte,
  output logic       o_byte_valid,
  output logic       o_byte_err
);

  localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_byte_valid;
  logic             w_byte_valid_nxt;
  logic             r_byte_err;
  logic             w_byte_err_nxt;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_byte_valid <= 1'b0;
      r_byte_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_byte_err   <= w_byte_err_nxt;
    end
  end

  // Next-state logic: start bit re-checked at mid-bit, data and stop bits one bit-time apart.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_bit_idx_nxt    = r_bit_idx;
    w_shift_nxt      = r_shift;
    w_byte_valid_nxt = 1'b0;
    w_byte_err_nxt   = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt     = '0;
        w_bit_idx_nxt = 3'd0;
        if (r_prev && !r_sync2) begin
          w_state_nxt = RX_START;
        end else begin
          w_state_nxt = RX_IDLE;
        end
      end
      RX_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          if (!r_sync2) begin
            w_state_nxt = RX_DATA;
          end else begin
            w_state_nxt = RX_IDLE;   // too short to be a start bit
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_nxt = 3'd0;
            w_state_nxt   = RX_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
          if (r_sync2) begin
            w_byte_valid_nxt = 1'b1;
          end else begin
            w_byte_err_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_rx_byte    = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_byte_err   = r_byte_err;

endmodule

// File: rtl/uart_rgb_ctrl.sv
// UART frame parser: sync/R/G/B frames update the three duty outputs at once,
// with a one-cycle valid strobe; incomplete frames are dropped after a timeout.
module uart_rgb_ctrl
  import uart_rgb_ctrl_pkg::*;
#(
  parameter int         CLOCK_FREQ     = 10_000_000,
  parameter int         BAUD           = 115200,
  parameter int         CLOCKS_PER_BIT = calc_clocks_per_bit(CLOCK_FREQ, BAUD),
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CLKS   = 16 * CLOCKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_rxd,
  output logic [7:0] duty_red,
  output logic [7:0] duty_green,
  output logic [7:0] duty_blue,
  output logic       duty_valid,
  output logic       frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  logic [7:0]   w_rx_byte;
  logic         w_byte_valid;
  logic         w_byte_err;
  logic         w_timeout;
  parse_state_t r_pstate;
  parse_state_t w_pstate_nxt;
  logic [7:0]   r_r_tmp;
  logic [7:0]   w_r_tmp_nxt;
  logic [7:0]   r_g_tmp;
  logic [7:0]   w_g_tmp_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_cnt_nxt;
  logic [7:0]   w_red_nxt;
  logic [7:0]   w_green_nxt;
  logic [7:0]   w_blue_nxt;
  logic         w_duty_valid_nxt;
  logic         w_frame_err_nxt;

  uart_rx #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_rxd       (serial_rxd),
    .o_rx_byte   (w_rx_byte),
    .o_byte_valid(w_byte_valid),
    .o_byte_err  (w_byte_err)
  );

  // Parser state, partial colour bytes, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pstate   <= P_WAIT_SYNC;
      r_r_tmp    <= 8'h00;
      r_g_tmp    <= 8'h00;
      r_to_cnt   <= '0;
      duty_red   <= 8'h00;
      duty_green <= 8'h00;
      duty_blue  <= 8'h00;
      duty_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_pstate   <= w_pstate_nxt;
      r_r_tmp    <= w_r_tmp_nxt;
      r_g_tmp    <= w_g_tmp_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      duty_red   <= w_red_nxt;
      duty_green <= w_green_nxt;
      duty_blue  <= w_blue_nxt;
      duty_valid <= w_duty_valid_nxt;
      frame_err  <= w_frame_err_nxt;
    end
  end

  // Frame sequencing; a received byte takes priority over a coincident timeout.
  always_comb begin
    w_pstate_nxt     = r_pstate;
    w_r_tmp_nxt      = r_r_tmp;
    w_g_tmp_nxt      = r_g_tmp;
    w_red_nxt        = duty_red;
    w_green_nxt      = duty_green;
    w_blue_nxt       = duty_blue;
    w_duty_valid_nxt = 1'b0;
    w_frame_err_nxt  = w_byte_err;
    w_timeout        = (r_pstate != P_WAIT_SYNC) && (r_to_cnt == TO_LAST);

    if (w_byte_valid || (r_pstate == P_WAIT_SYNC)) begin
      w_to_cnt_nxt = '0;
    end else begin
      w_to_cnt_nxt = r_to_cnt + TO_W'(1);
    end

    if (w_byte_err) begin
      w_pstate_nxt = P_WAIT_SYNC;
    end else if (w_byte_valid) begin
      case (r_pstate)
        P_WAIT_SYNC: begin
          if (w_rx_byte == SYNC_BYTE) begin
            w_pstate_nxt = P_GET_R;
          end else begin
            w_pstate_nxt = P_WAIT_SYNC;
          end
        end
        P_GET_R: begin
          w_r_tmp_nxt  = w_rx_byte;
          w_pstate_nxt = P_GET_G;
        end
        P_GET_G: begin
          w_g_tmp_nxt  = w_rx_byte;
          w_pstate_nxt = P_GET_B;
        end
        P_GET_B: begin
          w_red_nxt        = r_r_tmp;
          w_green_nxt      = r_g_tmp;
          w_blue_nxt       = w_rx_byte;
          w_duty_valid_nxt = 1'b1;
          w_pstate_nxt     = P_WAIT_SYNC;
        end
        default: begin
          w_pstate_nxt = P_WAIT_SYNC;
        end
      endcase
    end else if (w_timeout) begin
      w_pstate_nxt = P_WAIT_SYNC;
    end else begin
      w_pstate_nxt = r_pstate;
    end
  end

endmodule
